// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree and its frame accumulator.
package adder_tree_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = 32'sd1;
        while (v < n) begin
            v = v * 32'sd2;
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Element width after s pairing levels; one growth bit per level keeps sums exact.
    function automatic int stage_width(input int dwidth, input int s);
        return dwidth + s;
    endfunction

    function automatic int stage_count(input int n, input int s);
        int c;
        c = n;
        for (int i = 0; i < s; i++) begin
            c = (c + 32'sd1) / 32'sd2;
        end
        return c;
    endfunction

    // Bit offset of level s inside the flattened level bus (levels packed back to back).
    function automatic int level_offset(input int n, input int dwidth, input int s);
        int off;
        off = 32'sd0;
        for (int i = 0; i < s; i++) begin
            off = off + stage_count(n, i) * stage_width(dwidth, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered pairing level of the adder tree; an odd last element passes through widened.
module adder_tree_stage
    import adder_tree_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int IN_W   = 8,
    parameter int SIGNED = 0,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int OUT_W = IN_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_IN*IN_W-1:0]   in_dat,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic [N_OUT*OUT_W-1:0] out_dat,
    output logic                   out_valid,
    output logic                   out_last
);

    logic [N_OUT*OUT_W-1:0] sum_s;

    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] x);
        return (SIGNED != 0) ? {x[IN_W-1], x} : {1'b0, x};
    endfunction

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_IN) begin : g_add
            assign sum_s[j*OUT_W +: OUT_W] = ext(in_dat[(2*j)*IN_W +: IN_W])
                                           + ext(in_dat[(2*j+1)*IN_W +: IN_W]);
        end else begin : g_pass
            assign sum_s[j*OUT_W +: OUT_W] = ext(in_dat[(2*j)*IN_W +: IN_W]);
        end
    end

    // Level register: captures sums and beat tags only when the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_dat   <= sum_s;
            out_valid <= in_valid;
            out_last  <= in_last;
        end
    end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined adder tree over NUM_INPUTS lanes with per-frame accumulation and a
// single global advance that stalls the whole pipeline under output backpressure.
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int NUM_INPUTS = 12,
    parameter int DWIDTH     = 8,
    parameter int SIGNED     = 0,
    parameter int ACC_EXTRA  = 8,
    localparam int NUM_STAGES = clog2(NUM_INPUTS),
    localparam int OWIDTH     = DWIDTH + NUM_STAGES + ACC_EXTRA
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_INPUTS*DWIDTH-1:0] i_dat_vector,
    input  logic                         i_dat_valid,
    input  logic                         i_dat_last,
    output logic                         o_dat_ready,
    output logic [OWIDTH-1:0]            o_sum,
    output logic                         o_sum_valid,
    output logic                         o_sum_ovf,
    input  logic                         i_sum_ready
);

    localparam int TREE_W  = DWIDTH + NUM_STAGES;
    localparam int BUS_W   = level_offset(NUM_INPUTS, DWIDTH, NUM_STAGES + 1);
    localparam int FIN_OFF = level_offset(NUM_INPUTS, DWIDTH, NUM_STAGES);

    logic                         advance_s;
    logic [NUM_INPUTS*DWIDTH-1:0] in_dat_r;
    logic                         in_valid_r;
    logic                         in_last_r;
    logic [BUS_W-1:0]             lvl_bus_s;
    logic [NUM_STAGES:0]          lvl_valid_s;
    logic [NUM_STAGES:0]          lvl_last_s;
    logic [TREE_W-1:0]            tree_s;
    logic                         fin_valid_s;
    logic                         fin_last_s;
    logic [OWIDTH-1:0]            tree_ext_s;
    logic [OWIDTH:0]              add_full_s;
    logic                         add_ovf_s;
    logic [OWIDTH-1:0]            acc_nxt_s;
    logic                         ovf_nxt_s;
    logic [OWIDTH-1:0]            acc_r;
    logic                         ovf_r;
    logic                         in_frame_r;

    assign advance_s   = !o_sum_valid || i_sum_ready;
    assign o_dat_ready = advance_s;

    // Input capture register (level 0 of the tree).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_dat_r   <= '0;
            in_valid_r <= 1'b0;
            in_last_r  <= 1'b0;
        end else if (advance_s) begin
            in_dat_r   <= i_dat_vector;
            in_valid_r <= i_dat_valid;
            in_last_r  <= i_dat_last;
        end
    end

    assign lvl_bus_s[0 +: NUM_INPUTS*DWIDTH] = in_dat_r;
    assign lvl_valid_s[0]                    = in_valid_r;
    assign lvl_last_s[0]                     = in_last_r;

    for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_stage
        localparam int N_PREV   = stage_count(NUM_INPUTS, s - 1);
        localparam int W_PREV   = stage_width(DWIDTH, s - 1);
        localparam int N_CUR    = stage_count(NUM_INPUTS, s);
        localparam int W_CUR    = stage_width(DWIDTH, s);
        localparam int OFF_PREV = level_offset(NUM_INPUTS, DWIDTH, s - 1);
        localparam int OFF_CUR  = level_offset(NUM_INPUTS, DWIDTH, s);

        adder_tree_stage #(
            .N_IN   (N_PREV),
            .IN_W   (W_PREV),
            .SIGNED (SIGNED)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance_s),
            .in_dat    (lvl_bus_s[OFF_PREV +: N_PREV*W_PREV]),
            .in_valid  (lvl_valid_s[s-1]),
            .in_last   (lvl_last_s[s-1]),
            .out_dat   (lvl_bus_s[OFF_CUR +: N_CUR*W_CUR]),
            .out_valid (lvl_valid_s[s]),
            .out_last  (lvl_last_s[s])
        );
    end

    assign tree_s      = lvl_bus_s[FIN_OFF +: TREE_W];
    assign fin_valid_s = lvl_valid_s[NUM_STAGES];
    assign fin_last_s  = lvl_last_s[NUM_STAGES];

    if (SIGNED != 0) begin : g_sext
        assign tree_ext_s = OWIDTH'($signed(tree_s));
    end else begin : g_zext
        assign tree_ext_s = OWIDTH'(tree_s);
    end

    // Next accumulator value; signed overflow is carry-into-MSB xor carry-out.
    always_comb begin
        add_full_s = {1'b0, acc_r} + {1'b0, tree_ext_s};
        if (SIGNED != 0) begin
            add_ovf_s = add_full_s[OWIDTH] ^ add_full_s[OWIDTH-1]
                      ^ acc_r[OWIDTH-1] ^ tree_ext_s[OWIDTH-1];
        end else begin
            add_ovf_s = add_full_s[OWIDTH];
        end
        if (!in_frame_r) begin
            acc_nxt_s = tree_ext_s;
            ovf_nxt_s = 1'b0;
        end else begin
            acc_nxt_s = add_full_s[OWIDTH-1:0];
            ovf_nxt_s = ovf_r | add_ovf_s;
        end
    end

    // Frame accumulator and registered sum output; bubbles leave frame state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            in_frame_r  <= 1'b0;
            o_sum       <= '0;
            o_sum_ovf   <= 1'b0;
            o_sum_valid <= 1'b0;
        end else if (advance_s) begin
            if (fin_valid_s) begin
                acc_r      <= acc_nxt_s;
                ovf_r      <= ovf_nxt_s;
                in_frame_r <= !fin_last_s;
            end
            if (fin_valid_s && fin_last_s) begin
                o_sum       <= acc_nxt_s;
                o_sum_ovf   <= ovf_nxt_s;
                o_sum_valid <= 1'b1;
            end else begin
                o_sum_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: three configurations (12x8 unsigned, 5x8 signed,
// 12x8 unsigned without guard bits) sharing one clock and reset.
module tb_adder_tree_acc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [95:0] a_vec;  logic a_valid, a_last, a_ready, a_sv, a_ovf, a_srdy; logic [19:0] a_sum;
    logic [39:0] b_vec;  logic b_valid, b_last, b_ready, b_sv, b_ovf, b_srdy; logic [18:0] b_sum;
    logic [95:0] c_vec;  logic c_valid, c_last, c_ready, c_sv, c_ovf, c_srdy; logic [11:0] c_sum;

    adder_tree_acc #(.NUM_INPUTS(12), .DWIDTH(8), .SIGNED(0), .ACC_EXTRA(8)) u_a (
        .clk(clk), .rst_n(rst_n), .i_dat_vector(a_vec), .i_dat_valid(a_valid),
        .i_dat_last(a_last), .o_dat_ready(a_ready), .o_sum(a_sum), .o_sum_valid(a_sv),
        .o_sum_ovf(a_ovf), .i_sum_ready(a_srdy));

    adder_tree_acc #(.NUM_INPUTS(5), .DWIDTH(8), .SIGNED(1), .ACC_EXTRA(8)) u_b (
        .clk(clk), .rst_n(rst_n), .i_dat_vector(b_vec), .i_dat_valid(b_valid),
        .i_dat_last(b_last), .o_dat_ready(b_ready), .o_sum(b_sum), .o_sum_valid(b_sv),
        .o_sum_ovf(b_ovf), .i_sum_ready(b_srdy));

    adder_tree_acc #(.NUM_INPUTS(12), .DWIDTH(8), .SIGNED(0), .ACC_EXTRA(0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_dat_vector(c_vec), .i_dat_valid(c_valid),
        .i_dat_last(c_last), .o_dat_ready(c_ready), .o_sum(c_sum), .o_sum_valid(c_sv),
        .o_sum_ovf(c_ovf), .i_sum_ready(c_srdy));

    typedef struct {
        int          sel;
        logic [95:0] vec;
        logic [31:0] exp_sum;
        int          exp_lat;
    } vec_t;

    vec_t        tbl [0:7];
    int          total = 0;
    int          bad   = 0;
    logic [32:0] a_q [$];
    logic [32:0] c_q [$];

    // Record every accepted sum as {ovf, sum}.
    always @(negedge clk) begin
        if (a_sv && a_srdy) a_q.push_back({a_ovf, 32'(a_sum)});
        if (c_sv && c_srdy) c_q.push_back({c_ovf, 32'(c_sum)});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_sv(input int sel);
        case (sel)
            0:       return a_sv;
            1:       return b_sv;
            default: return c_sv;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int sel);
        case (sel)
            0:       return 32'(a_sum);
            1:       return 32'($signed(b_sum));
            default: return 32'(c_sum);
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0:       return a_ovf;
            1:       return b_ovf;
            default: return c_ovf;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return a_ready;
            1:       return b_ready;
            default: return c_ready;
        endcase
    endfunction

    task automatic drive(input int sel, input logic [95:0] v, input logic vld, input logic lst);
        case (sel)
            0:       begin a_vec = v;       a_valid = vld; a_last = lst; end
            1:       begin b_vec = v[39:0]; b_valid = vld; b_last = lst; end
            default: begin c_vec = v;       c_valid = vld; c_last = lst; end
        endcase
    endtask

    task automatic beat(input int sel, input logic [95:0] v, input logic lst);
        @(posedge clk); #1;
        drive(sel, v, 1'b1, lst);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) drive(s, 96'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_q(input int sel, input int n);
        for (int k = 0; k < 60; k++) begin
            if ((sel == 0 ? a_q.size() : c_q.size()) >= n) break;
            @(posedge clk);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int idx;
        int cyc;

        tbl[0] = '{0, {12{8'hFF}}, 32'd3060, 5};
        tbl[1] = '{0, 96'h0, 32'd0, 5};
        tbl[2] = '{0, {8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, 32'd66, 5};
        tbl[3] = '{0, {8'd2, 8'd1, 8'd100, 8'd200, 64'h0}, 32'd303, 5};
        tbl[4] = '{0, {6{8'h00, 8'hFF}}, 32'd1530, 5};
        tbl[5] = '{1, {56'h0, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80}, 32'hFFFF_FE7F, 4};
        tbl[6] = '{1, {56'h0, {5{8'hFF}}}, 32'hFFFF_FFFB, 4};
        tbl[7] = '{1, {56'h0, {5{8'h7F}}}, 32'd635, 4};

        rst_n = 1'b0;
        a_srdy = 1'b1; b_srdy = 1'b1; c_srdy = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 96'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", {61'h0, a_ready, b_ready, c_ready}, 64'h7);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_sv%0d", s), 64'(get_sv(s)), 64'h0);
            check($sformatf("reset_sum%0d", s), 64'(get_sum(s)), 64'h0);
            check($sformatf("reset_ready%0d", s), 64'(get_ready(s)), 64'h1);
        end

        // Single-beat frames: value, overflow flag and exact latency.
        for (int i = 0; i < 8; i++) begin
            beat(tbl[i].sel, tbl[i].vec, 1'b1);
            k = 0;
            do begin
                @(posedge clk); #1;
                k++;
                if (k == 1) drive(tbl[i].sel, 96'h0, 1'b0, 1'b0);
            end while (!get_sv(tbl[i].sel) && k < 20);
            check($sformatf("lat[%0d]", i), 64'(k - 1), 64'(tbl[i].exp_lat));
            check($sformatf("sum[%0d]", i), 64'(get_sum(tbl[i].sel)), 64'(tbl[i].exp_sum));
            check($sformatf("ovf[%0d]", i), 64'(get_ovf(tbl[i].sel)), 64'h0);
        end

        // Multi-beat frame with a bubble, then a back-to-back single-beat frame.
        idle();
        a_q.delete();
        beat(0, {12{8'd1}}, 1'b0);
        idle();
        beat(0, {12{8'd1}}, 1'b0);
        beat(0, {12{8'd1}}, 1'b1);
        beat(0, {12{8'd2}}, 1'b1);
        idle();
        wait_q(0, 2);
        check("multi_count", 64'(a_q.size()), 64'd2);
        if (a_q.size() >= 2) begin
            check("multi_sum0", 64'(a_q[0]), {31'h0, 1'b0, 32'd36});
            check("multi_sum1", 64'(a_q[1]), {31'h0, 1'b0, 32'd24});
        end

        // Backpressure: 10 stalled cycles with continuous input, 8 frames of 12*f.
        a_q.delete();
        idx = 1;
        cyc = 0;
        while (idx <= 8 && cyc < 100) begin
            @(posedge clk); #1;
            a_srdy = !(cyc >= 3 && cyc <= 12);
            drive(0, {12{8'(idx)}}, 1'b1, 1'b1);
            #1;
            if (cyc >= 8 && cyc <= 12) begin
                check($sformatf("bp_ready@%0d", cyc), 64'(a_ready), 64'h0);
                check($sformatf("bp_hold@%0d", cyc), 64'(a_sum), 64'd12);
            end
            if (a_ready) idx++;
            cyc++;
        end
        idle();
        wait_q(0, 8);
        check("bp_count", 64'(a_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < a_q.size(); i++) begin
            check($sformatf("bp_frame[%0d]", i), 64'(a_q[i]), {31'h0, 1'b0, 32'(12 * (i + 1))});
        end

        // No guard bits: two full-scale beats wrap and flag; the next frame clears the flag.
        c_q.delete();
        beat(2, {12{8'hFF}}, 1'b0);
        beat(2, {12{8'hFF}}, 1'b1);
        beat(2, {12{8'hFF}}, 1'b1);
        idle();
        wait_q(2, 2);
        check("ovf_count", 64'(c_q.size()), 64'd2);
        if (c_q.size() >= 2) begin
            check("ovf_wrap", 64'(c_q[0]), {31'h0, 1'b1, 32'd2024});
            check("ovf_clear", 64'(c_q[1]), {31'h0, 1'b0, 32'd3060});
        end

        // Reset mid-frame: the partial frame must not leak into the next sum.
        c_q.delete();
        beat(2, {12{8'hFF}}, 1'b0);
        idle();
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(c_ready), 64'h1);
        check("midrst_sum", 64'(c_sum), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(2, {12{8'd1}}, 1'b1);
        idle();
        wait_q(2, 1);
        check("midrst_count", 64'(c_q.size()), 64'd1);
        if (c_q.size() >= 1) begin
            check("midrst_frame", 64'(c_q[0]), {31'h0, 1'b0, 32'd12});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
